// File: rtl/mem_pkg.sv
// Shared encodings for the data memory unit: access sizes and controller states.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte-enables and replicated data,
// load lane extraction with sign/zero extension, and alignment checking.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_sh,
    output logic [31:0] o_load_val,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    // Store data is replicated across lanes so the byte-enables alone pick the target.
    always_comb begin
        o_be         = 4'b0000;
        o_wdata_sh   = 32'h0;
        o_load_val   = 32'h0;
        o_misaligned = 1'b0;
        case (size_t'(i_size))
            SZ_BYTE: begin
                o_be       = 4'b0001 << i_lane;
                o_wdata_sh = {4{i_wdata[7:0]}};
                o_load_val = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_misaligned = i_lane[0];
                o_be         = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata_sh   = {2{i_wdata[15:0]}};
                o_load_val   = {{16{i_sign_ext & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_misaligned = (i_lane != 2'b00);
                o_be         = 4'b1111;
                o_wdata_sh   = i_wdata;
                o_load_val   = i_rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory with req/ready/done handshake, configurable access
// latency, sized loads/stores and write-back select.
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] alu_result,
    input  logic        mem_to_reg,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [31:0] write_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic            r_we, r_sign_ext, r_err;
    logic [1:0]      r_size;
    logic [31:0]     r_addr, r_wdata, r_load_data;
    logic [31:0]     r_mem [DEPTH] = '{default: 32'h0};

    logic [AW-1:0]   w_idx;
    logic [31:0]     w_rword, w_wdata_sh, w_load_val;
    logic [3:0]      w_be;
    logic            w_misaligned, w_oor, w_err, w_finish, w_store;

    assign w_idx    = r_addr[AW+1:2];
    assign w_rword  = r_mem[w_idx];
    assign w_oor    = |r_addr[31:AW+2];
    assign w_err    = w_misaligned | w_oor | (r_size == SZ_RSVD);
    assign w_finish = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_store  = w_finish && r_we && !w_err;

    mem_lane_align u_align (
        .i_size       (r_size),
        .i_lane       (r_addr[1:0]),
        .i_sign_ext   (r_sign_ext),
        .i_wdata      (r_wdata),
        .i_rword      (w_rword),
        .o_be         (w_be),
        .o_wdata_sh   (w_wdata_sh),
        .o_load_val   (w_load_val),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: if (req) begin
                w_state_next = ST_BUSY;
                w_cnt_next   = CW'(LATENCY - 1);
            end
            ST_BUSY: begin
                if (r_cnt == '0) w_state_next = ST_DONE;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_sign_ext  <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_err       <= 1'b0;
            r_load_data <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_IDLE && req) begin
                r_we       <= we;
                r_size     <= size;
                r_sign_ext <= sign_ext;
                r_addr     <= addr;
                r_wdata    <= wdata;
            end
            if (w_finish) begin
                r_err <= w_err;
                // Completed stores leave the last load result untouched.
                if (w_err)      r_load_data <= 32'h0;
                else if (!r_we) r_load_data <= w_load_val;
            end
        end
    end

    // The array has no reset: a reset only aborts the FSM, never the contents.
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
            end
        end
    end

    assign ready      = (r_state == ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign err        = r_err;
    assign load_data  = r_load_data;
    assign write_data = mem_to_reg ? r_load_data : alu_result;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: a LATENCY=1 instance for data paths and
// errors, plus a LATENCY=4 instance for handshake spacing.
module tb_data_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, sign_ext, mem_to_reg;
    logic [1:0]  size;
    logic [31:0] addr, wdata, alu_result;
    logic        ready, done, err;
    logic [31:0] load_data, write_data;

    logic        req4;
    logic        ready4, done4, err4;
    logic [31:0] load_data4, write_data4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_unit #(.DEPTH(64), .LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .alu_result(alu_result), .mem_to_reg(mem_to_reg),
        .ready(ready), .done(done), .err(err),
        .load_data(load_data), .write_data(write_data)
    );

    data_mem_unit #(.DEPTH(64), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .req(req4), .we(1'b0), .size(2'b10),
        .sign_ext(1'b0), .addr(32'h0), .wdata(32'h0),
        .alu_result(32'h0), .mem_to_reg(1'b1),
        .ready(ready4), .done(done4), .err(err4),
        .load_data(load_data4), .write_data(write_data4)
    );

    // Issues one request (caller is positioned between edges) and follows it
    // until ready returns, reporting done latency, err, load_data and stall length.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e, output logic [31:0] ld,
                          output int rdy_low, output logic tmo);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; e = 1'b0; ld = 32'h0; rdy_low = 0; tmo = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done) begin lat = n; e = err; ld = load_data; end
            if (ready) begin tmo = 1'b0; break; end
            rdy_low++;
        end
        $display("access we=%0b size=%0d sx=%0b addr=%h wdata=%h -> lat=%0d err=%0b load_data=%h",
                 w, sz, sx, a, d, lat, e, ld);
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 1'b0; req4 = 1'b0; we = 1'b0; size = 2'b10;
        sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0;
        alu_result = 32'h0; mem_to_reg = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data: got %h want 0", load_data); end
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4: got %b want 1", ready4); end
        reset = 1'b0;
    endtask

    task automatic test_word;
        int lat, rl; logic e, t; logic [31:0] ld;
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, e, ld, rl, t);
        checks++; if (t || lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
        checks++; if (rl != 2) begin errors++; $display("FAIL sw_ready_low: got %0d want 2", rl); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", e); end
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, ld, rl, t);
        checks++; if (t || lat != 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
        checks++; if (ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", ld); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", e); end
    endtask

    task automatic test_byte_half;
        int lat, rl; logic e, t; logic [31:0] ld;
        access(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F, lat, e, ld, rl, t);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'hDEAD7FEF) begin errors++; $display("FAIL sb_word: got %h want dead7fef", ld); end
        access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'h0000007F) begin errors++; $display("FAIL lb_11: got %h want 0000007f", ld); end
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'h000000DE) begin errors++; $display("FAIL lbu_13: got %h want 000000de", ld); end
        access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_12: got %h want ffffdead", ld); end
        access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_10: got %h want ffffffef", ld); end
        access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'h00007FEF) begin errors++; $display("FAIL lhu_10: got %h want 00007fef", ld); end
        access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'hDEAD7FEF) begin errors++; $display("FAIL lw_sext_ignored: got %h want dead7fef", ld); end
    endtask

    task automatic test_errors;
        int lat, rl; logic e, t; logic [31:0] ld;
        access(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000AAAA, lat, e, ld, rl, t);
        checks++; if (e !== 1'b1 || lat != 2) begin errors++; $display("FAIL sh_misaligned_err: got err=%b lat=%0d want err=1 lat=2", e, lat); end
        checks++; if (ld !== 32'h0) begin errors++; $display("FAIL sh_misaligned_ld: got %h want 0", ld); end
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, ld, rl, t);
        access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, lat, e, ld, rl, t);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL lw_misaligned_err: got %b want 1", e); end
        checks++; if (ld !== 32'h0) begin errors++; $display("FAIL lw_misaligned_ld: got %h want 0", ld); end
        access(1'b1, 2'b10, 1'b0, 32'h100, 32'h11111111, lat, e, ld, rl, t);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL sw_oor_err: got %b want 1", e); end
        access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, e, ld, rl, t);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL rsvd_size_err: got %b want 1", e); end
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, ld, rl, t);
        checks++; if (e !== 1'b0 || ld !== 32'hDEAD7FEF) begin errors++; $display("FAIL post_err_lw: got err=%b %h want err=0 dead7fef", e, ld); end
        // 0x100 aliases to word 0 if the range check is lost
        access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'h0) begin errors++; $display("FAIL oor_store_suppressed: got %h want 0", ld); end
    endtask

    task automatic test_store_keeps_load;
        int lat, rl; logic e, t; logic [31:0] ld;
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, ld, rl, t);
        access(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, lat, e, ld, rl, t);
        checks++; if (load_data !== 32'hDEAD7FEF) begin errors++; $display("FAIL store_keeps_load: got %h want dead7fef", load_data); end
        access(1'b1, 2'b01, 1'b0, 32'h6, 32'h9999ABCD, lat, e, ld, rl, t);
        access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'hABCD3344) begin errors++; $display("FAIL sh_upper_lanes: got %h want abcd3344", ld); end
    endtask

    task automatic test_wb_mux;
        int lat, rl; logic e, t; logic [31:0] ld;
        access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, e, ld, rl, t);
        #1 alu_result = 32'hA5A5A5A5; mem_to_reg = 1'b0;
        #1;
        checks++; if (write_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL wb_alu: got %h want a5a5a5a5", write_data); end
        mem_to_reg = 1'b1;
        #1;
        checks++; if (write_data !== 32'h0000007F) begin errors++; $display("FAIL wb_load: got %h want 0000007f", write_data); end
        mem_to_reg = 1'b0;
        #1;
        checks++; if (write_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL wb_alu_again: got %h want a5a5a5a5", write_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, rl; logic e, t; logic [31:0] ld;
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk);
        #1 req = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midreset_handshake: got ready=%b done=%b want 1 0", ready, done); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL midreset_load_data: got %h want 0", load_data); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, ld, rl, t);
        checks++; if (t || lat != 2) begin errors++; $display("FAIL postreset_accept: got lat=%0d want 2", lat); end
        checks++; if (ld !== 32'h0) begin errors++; $display("FAIL midreset_store_dropped: got %h want 0", ld); end
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, ld, rl, t);
        checks++; if (ld !== 32'hDEAD7FEF) begin errors++; $display("FAIL mem_survives_reset: got %h want dead7fef", ld); end
    endtask

    task automatic test_latency4;
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL lat4_idle: got %b want 1", ready4); end
        req4 = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            checks++;
            if (ready4 !== (i % 6 == 0) || done4 !== (i % 6 == 5)) begin
                errors++;
                $display("FAIL lat4_cycle%0d: got ready=%b done=%b want ready=%b done=%b",
                         i, ready4, done4, (i % 6 == 0), (i % 6 == 5));
            end
        end
        req4 = 1'b0;
        $display("lat4 burst of 24 cycles with req held high complete");
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte_half;
        test_errors;
        test_store_keeps_load;
        test_wb_mux;
        test_reset_mid;
        test_latency4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
